// File: rtl/regbank_write_arbiter_pkg.sv
// Shared types and constants for the register-bank write arbiter.
// Bank geometry lives here so the arbiter, its interface and the decoder agree on it.
package regbank_arb_pkg;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;
    localparam int SRC_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CLEAR
    } state_t;

    function automatic logic [NUM_REGS-1:0] onehot_dec(input logic [ADDR_W-1:0] idx);
        logic [NUM_REGS-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/regbank_write_arbiter_if.sv
// Requester handshake plus bank write port of the register-bank write arbiter.
// The master side drives requests and observes the bank port; the arbiter is the slave.
interface regbank_write_arbiter_if
    import regbank_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      regWrite;
    logic [NUM_REGS-1:0]       decOut;
    logic [DATA_W-1:0]         wrData;
    logic [SRC_W-1:0]          wr_src;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, regWrite, decOut, wrData, wr_src
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, regWrite, decOut, wrData, wr_src
    );

endinterface

// File: rtl/regbank_write_arbiter_rr_arbiter.sv
// Combinational round-robin grant: search starts one past the pointer, first valid wins.
// With REGARB_FIXED_PRIO_EN defined, requester 0 pre-empts the round-robin search.
module rr_arbiter
    import regbank_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   winner
);

    logic found;
    int   cand;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        cand   = 0;
`ifdef REGARB_FIXED_PRIO_EN
        if (valid[0]) begin
            grant[0] = 1'b1;
            found    = 1'b1;
        end
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && valid[cand]) begin
                grant[cand] = 1'b1;
                winner      = SRC_W'(cand);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Owns the register bank's single write port: round-robin requesters plus a clear sweep.
// Optional REGARB_FIXED_PRIO_EN gives requester 0 absolute priority.
module regbank_write_arbiter
    import regbank_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    regbank_write_arbiter_if.slave   bus,
    input  logic                     clr_start,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam logic [SRC_W-1:0]  PTR_INIT = SRC_W'(NUM_REQ - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t                state_q, state_d;
    logic [SRC_W-1:0]      ptr_q, ptr_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic [NUM_REGS-1:0]   dec_q, dec_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [SRC_W-1:0]      src_q, src_d;
    logic                  done_q, done_d;

    logic [NUM_REQ-1:0]    grant;
    logic [SRC_W-1:0]      winner;
    logic                  accept;
    logic [ADDR_W-1:0]     win_addr;
    logic [DATA_W-1:0]     win_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .valid  (bus.req_valid),
        .ptr    (ptr_q),
        .grant  (grant),
        .winner (winner)
    );

    // A pending clear starves requesters for that cycle so the sweep starts cleanly.
    assign bus.req_ready = (reset && state_q != CLEAR && !clr_start) ? grant : '0;
    assign accept        = |(bus.req_ready & bus.req_valid);
    assign win_addr      = bus.req_addr[int'(winner)*ADDR_W +: ADDR_W];
    assign win_data      = bus.req_data[int'(winner)*DATA_W +: DATA_W];

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        wr_d    = 1'b0;
        dec_d   = '0;
        data_d  = '0;
        src_d   = '0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE, ISSUE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                    wr_d    = 1'b1;
                    dec_d   = NUM_REGS'(onehot_dec('0));
                end else if (accept) begin
                    state_d = ISSUE;
                    wr_d    = 1'b1;
                    dec_d   = NUM_REGS'(onehot_dec(win_addr));
                    data_d  = win_data;
                    src_d   = winner;
`ifdef REGARB_FIXED_PRIO_EN
                    if (winner != '0) ptr_d = winner;
`else
                    ptr_d   = winner;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    wr_d    = 1'b1;
                    dec_d   = NUM_REGS'(onehot_dec(idx_q + 1'b1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= PTR_INIT;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            dec_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            dec_q   <= dec_d;
            data_q  <= data_d;
            src_q   <= src_d;
            done_q  <= done_d;
        end
    end

    assign bus.regWrite = wr_q;
    assign bus.decOut   = dec_q;
    assign bus.wrData   = data_q;
    assign bus.wr_src   = src_q;
    assign clr_busy     = (state_q == CLEAR);
    assign clr_done     = done_q;

endmodule
